ws2812_frame_driver: RTL

Streams one frame of pixel bytes from the shared framebuffer to a WS2812-style single-wire LED chain. Sits downstream of the bus arbiter as one of its client channels: it fetches bytes with a level req/ready handshake, double-buffers one byte ahead, and serializes MSB-first with programmable high/low pulse timing. After the last bit it holds the line low for the latch interval, then signals completion.

---
 rtl/ws2812_frame_driver.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ws2812_frame_driver.sv
// rtl/ws2812_frame_driver.sv - fetches one frame of bytes over a req/ready channel and serializes it onto a WS2812 chain
// One byte is prefetched while the current byte shifts out; led_out drops low on an underrun.
module ws2812_frame_driver #(
  parameter int ADDRESS_WIDTH = 8,
  parameter int DATA_WIDTH    = 8,
  parameter int BASE_ADDR     = 0,
  parameter int NUM_BYTES     = 72,
  parameter int TBIT          = 30,
  parameter int T0H           = 9,
  parameter int T1H           = 17,
  parameter int RESET_CYCLES  = 1440
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     data_req,
  output logic [ADDRESS_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]    data_in,
  input  logic                     data_rdy,
  output logic                     led_out
);

  localparam int CYC_W = $clog2(TBIT);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int IDX_W = $clog2(NUM_BYTES + 1);
  localparam int LAT_W = $clog2(RESET_CYCLES + 1);
  localparam logic [ADDRESS_WIDTH-1:0] BASE  = ADDRESS_WIDTH'(BASE_ADDR);
  localparam logic [CYC_W-1:0]         T0H_C = CYC_W'(T0H);
  localparam logic [CYC_W-1:0]         T1H_C = CYC_W'(T1H);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SHIFT, S_STALL, S_LATCH} state_t;

  state_t                   r_state, w_state_next;
  logic                     r_busy, r_done, r_req, r_led;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [IDX_W-1:0]         r_fetch_idx, r_loaded;
  logic [DATA_WIDTH-1:0]    r_buf, r_shift, w_shift_next;
  logic                     r_buf_valid;
  logic [CYC_W-1:0]         r_cyc, w_cyc_next;
  logic [BIT_W-1:0]         r_bit, w_bit_next;
  logic [LAT_W-1:0]         r_lat;
  logic                     w_load, w_led_next;

  wire w_bit_last   = (r_cyc == CYC_W'(TBIT - 1));
  wire w_byte_end   = w_bit_last && (r_bit == BIT_W'(DATA_WIDTH - 1));
  wire w_all_loaded = (r_loaded == IDX_W'(NUM_BYTES));
  wire w_latch_end  = (r_lat == LAT_W'(RESET_CYCLES - 1));
  wire w_active     = (r_state == S_PRIME) || (r_state == S_SHIFT) || (r_state == S_STALL);
  wire w_capture    = r_req && data_rdy;
  wire w_fetch_go   = w_active && !r_req && !data_rdy && !r_buf_valid
                      && (r_fetch_idx < IDX_W'(NUM_BYTES));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_PRIME;
      S_PRIME: if (r_buf_valid) begin
        w_load       = 1'b1;
        w_state_next = S_SHIFT;
      end
      S_SHIFT: if (w_byte_end) begin
        if (w_all_loaded)     w_state_next = S_LATCH;
        else if (r_buf_valid) w_load       = 1'b1;
        else                  w_state_next = S_STALL;
      end
      S_STALL: if (r_buf_valid) begin
        w_load       = 1'b1;
        w_state_next = S_SHIFT;
      end
      S_LATCH: if (w_latch_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // led_out is registered, so the pulse level is computed from the next-cycle bit position
  always_comb begin
    w_shift_next = r_shift;
    w_cyc_next   = r_cyc;
    w_bit_next   = r_bit;
    if (w_load) begin
      w_shift_next = r_buf;
      w_cyc_next   = '0;
      w_bit_next   = '0;
    end else if (r_state == S_SHIFT) begin
      if (w_bit_last) begin
        w_cyc_next   = '0;
        w_bit_next   = r_bit + BIT_W'(1);
        w_shift_next = r_shift << 1;
      end else begin
        w_cyc_next = r_cyc + CYC_W'(1);
      end
    end
    w_led_next = (w_state_next == S_SHIFT)
                 && (w_cyc_next < (w_shift_next[DATA_WIDTH-1] ? T1H_C : T0H_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_req       <= 1'b0;
      r_led       <= 1'b0;
      r_addr      <= '0;
      r_fetch_idx <= '0;
      r_loaded    <= '0;
      r_buf       <= '0;
      r_buf_valid <= 1'b0;
      r_shift     <= '0;
      r_cyc       <= '0;
      r_bit       <= '0;
      r_lat       <= '0;
    end else begin
      r_done  <= 1'b0;
      r_shift <= w_shift_next;
      r_cyc   <= w_cyc_next;
      r_bit   <= w_bit_next;
      r_led   <= w_led_next;
      if (r_state == S_IDLE && start) begin
        r_busy      <= 1'b1;
        r_req       <= 1'b1;
        r_addr      <= BASE;
        r_fetch_idx <= '0;
        r_loaded    <= '0;
        r_buf_valid <= 1'b0;
      end else begin
        if (w_capture) begin
          r_buf       <= data_in;
          r_buf_valid <= 1'b1;
          r_req       <= 1'b0;
          r_fetch_idx <= r_fetch_idx + IDX_W'(1);
        end else if (w_fetch_go) begin
          r_req  <= 1'b1;
          r_addr <= BASE + ADDRESS_WIDTH'(r_fetch_idx);
        end
        if (w_load) begin
          r_buf_valid <= 1'b0;
          r_loaded    <= r_loaded + IDX_W'(1);
        end
      end
      if (r_state == S_LATCH) begin
        r_lat <= r_lat + LAT_W'(1);
        if (w_latch_end) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
        end
      end else begin
        r_lat <= '0;
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign data_req  = r_req;
  assign data_addr = r_addr;
  assign led_out   = r_led;

endmodule
